// File: rtl/lock_sequencer_pkg.sv
// Shared types and constants for the lock sequencer and its timer.
// Holds the state encoding, counter widths and parameter defaults.
package lock_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    FEED    = 3'd2,
    CHECK   = 3'd3,
    UNLOCK  = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  // Digit index covers CODE_LEN up to 16; timer covers cycle counts up to 65535.
  localparam int IDX_W  = 4;
  localparam int TMR_W  = 16;
  localparam int FAIL_W = 4;

  localparam int DEF_CODE_LEN       = 4;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_LOCKOUT_CYCLES = 16;
  localparam int DEF_UNLOCK_CYCLES  = 8;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a done flag, shared by the UNLOCK and LOCKOUT phases.
// Loading N-1 gives a done flag on the N-th cycle after the load edge.
module lock_timer
  import lock_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_value,
  output logic             done
);

  logic [TMR_W-1:0] count;

  // Count down to zero and hold there until the next load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - TMR_W'(1);
    end else begin
      count <= count;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Collects a digit code, replays it into an external code accepter and
// applies the accept verdict with an unlock pulse or a timed lockout.
module lock_sequencer
  import lock_sequencer_pkg::*;
#(
  parameter int CODE_LEN       = DEF_CODE_LEN,
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              digit_valid,
  input  logic              digit_bit,
  output logic              digit_ready,
  input  logic              mode_sel,
  output logic              acc_next_digit,
  output logic              acc_switch,
  output logic              acc_reset,
  input  logic              acc_accept,
  output logic              unlocked,
  output logic              locked_out,
  output logic [FAIL_W-1:0] fail_count,
  output logic              busy
);

  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(CODE_LEN - 1);
  localparam logic [FAIL_W:0]   FAIL_LIMIT  = (FAIL_W + 1)'(MAX_FAILS);
  localparam logic [TMR_W-1:0]  UNLOCK_LOAD = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCK_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic              SINGLE      = (CODE_LEN == 1);

  state_t                 state;
  state_t                 next_state;
  logic [(1<<IDX_W)-1:0]  buffer;
  logic [IDX_W-1:0]       idx;
  logic                   mode;
  logic                   take;
  logic                   last_fail;
  logic                   timer_load;
  logic [TMR_W-1:0]       timer_value;
  logic                   timer_done;

  assign take      = digit_valid && digit_ready;
  assign last_fail = (({1'b0, fail_count} + (FAIL_W + 1)'(1)) == FAIL_LIMIT);

  // Next-state selection and timer loading.
  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      IDLE: begin
        if (take) begin
          next_state = SINGLE ? FEED : COLLECT;
        end else begin
          next_state = IDLE;
        end
      end
      COLLECT: begin
        if (take && (idx == LAST_IDX)) begin
          next_state = FEED;
        end else begin
          next_state = COLLECT;
        end
      end
      FEED: begin
        if (idx == LAST_IDX) begin
          next_state = CHECK;
        end else begin
          next_state = FEED;
        end
      end
      CHECK: begin
        timer_load = 1'b1;
        if (acc_accept) begin
          next_state  = UNLOCK;
          timer_value = UNLOCK_LOAD;
        end else if (last_fail) begin
          next_state  = LOCKOUT;
          timer_value = LOCK_LOAD;
        end else begin
          next_state  = IDLE;
          timer_load  = 1'b0;
        end
      end
      UNLOCK, LOCKOUT: begin
        if (timer_done) begin
          next_state = IDLE;
        end else begin
          next_state = state;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, digit buffer, index, latched mode, fail counter and pulse outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      buffer     <= '0;
      idx        <= '0;
      mode       <= 1'b0;
      fail_count <= '0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= next_state;
      unlocked   <= (next_state == UNLOCK);
      locked_out <= (next_state == LOCKOUT);
      case (state)
        IDLE: begin
          if (take) begin
            buffer[0] <= digit_bit;
            mode      <= mode_sel;
            idx       <= SINGLE ? IDX_W'(0) : IDX_W'(1);
          end
        end
        COLLECT: begin
          if (take) begin
            buffer[idx] <= digit_bit;
            idx         <= (idx == LAST_IDX) ? IDX_W'(0) : idx + IDX_W'(1);
          end
        end
        FEED: begin
          idx <= (idx == LAST_IDX) ? IDX_W'(0) : idx + IDX_W'(1);
        end
        CHECK: begin
          if (acc_accept) begin
            fail_count <= '0;
          end else if (last_fail) begin
            fail_count <= FAIL_W'(MAX_FAILS);
          end else begin
            fail_count <= fail_count + FAIL_W'(1);
          end
        end
        LOCKOUT: begin
          if (timer_done) begin
            fail_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  lock_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  assign digit_ready    = (state == IDLE) || (state == COLLECT);
  assign busy           = !digit_ready;
  assign acc_reset      = !((state == FEED) || (state == CHECK));
  assign acc_next_digit = (state == FEED) ? buffer[idx] : 1'b0;
  assign acc_switch     = mode;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer with a 1,1,1,1 code-accepter stub.
// Expected outputs come from a per-attempt timeline model (phases and durations).
module tb_lock_sequencer;

  localparam int L  = 4;
  localparam int MF = 3;
  localparam int LC = 16;
  localparam int UC = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       digit_valid = 1'b0;
  logic       digit_bit = 1'b0;
  logic       digit_ready;
  logic       mode_sel = 1'b0;
  logic       acc_next_digit;
  logic       acc_switch;
  logic       acc_reset;
  logic       acc_accept;
  logic       unlocked;
  logic       locked_out;
  logic [3:0] fail_count;
  logic       busy;

  int   vectors = 0;
  int   miscompares = 0;
  int   fc = 0;
  logic exp_mode = 1'b0;

  always #5 clock = ~clock;

  lock_sequencer dut (
    .clock(clock), .reset(reset), .digit_valid(digit_valid), .digit_bit(digit_bit),
    .digit_ready(digit_ready), .mode_sel(mode_sel), .acc_next_digit(acc_next_digit),
    .acc_switch(acc_switch), .acc_reset(acc_reset), .acc_accept(acc_accept),
    .unlocked(unlocked), .locked_out(locked_out), .fail_count(fail_count), .busy(busy)
  );

  // Accepter stub: shifts fed bits, flags 1 after the L-th bit if all were 1.
  logic [3:0] stub_sh;
  int         stub_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset || acc_reset) begin
      stub_sh    <= 4'b0000;
      stub_cnt   <= 0;
      acc_accept <= 1'b0;
    end else begin
      stub_sh <= {stub_sh[2:0], acc_next_digit};
      if (stub_cnt == L - 1) acc_accept <= ({stub_sh[2:0], acc_next_digit} == 4'b1111);
      if (stub_cnt < L) stub_cnt <= stub_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] obs_vec();
    return {digit_ready, busy, acc_reset, acc_next_digit, acc_switch,
            unlocked, locked_out, fail_count};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One attempt: entry phase, L feed cycles, check, then unlock/lockout/idle.
  task automatic run_attempt(input logic [3:0] code, input logic start_mode,
                             input bit toggle, input bit hold, input string tag);
    int got = 0;
    int cyc = 0;
    logic [10:0] exp;
    while (got < L && cyc < 40) begin
      if (hold || $urandom_range(0, 2) != 0) begin
        digit_valid = 1'b1;
        digit_bit   = code[got];
      end else begin
        digit_valid = 1'b0;
        digit_bit   = 1'($urandom);
      end
      if (got == 0) mode_sel = start_mode;
      else if (toggle) mode_sel = 1'($urandom);
      exp = {1'b1, 1'b0, 1'b1, 1'b0, exp_mode, 1'b0, 1'b0, 4'(fc)};
      vectors++;
      if (obs_vec() !== exp) begin
        miscompares++;
        $display("FAIL %s_entry cyc%0d: got %b want %b", tag, cyc, obs_vec(), exp);
      end
      step();
      if (digit_valid) begin
        if (got == 0) exp_mode = start_mode;
        got++;
      end
      cyc++;
    end
    vectors++;
    if (got != L) begin
      miscompares++;
      $display("FAIL %s_collect_timeout: got %0d digits want %0d", tag, got, L);
      return;
    end
    for (int k = 0; k < L + 1; k++) begin
      digit_valid = hold ? 1'b1 : 1'($urandom);
      digit_bit   = 1'($urandom);
      if (toggle) mode_sel = 1'($urandom);
      exp = {1'b0, 1'b1, 1'b0, (k < L) ? code[k] : 1'b0, exp_mode, 1'b0, 1'b0, 4'(fc)};
      vectors++;
      if (obs_vec() !== exp) begin
        miscompares++;
        $display("FAIL %s_feed k%0d: got %b want %b", tag, k, obs_vec(), exp);
      end
      step();
    end
    if (code == 4'b1111) begin
      fc = 0;
      for (int k = 0; k < UC; k++) begin
        if (toggle) mode_sel = 1'($urandom);
        exp = {1'b0, 1'b1, 1'b1, 1'b0, exp_mode, 1'b1, 1'b0, 4'd0};
        vectors++;
        if (obs_vec() !== exp) begin
          miscompares++;
          $display("FAIL %s_unlock k%0d: got %b want %b", tag, k, obs_vec(), exp);
        end
        step();
      end
    end else if (fc + 1 == MF) begin
      fc = MF;
      for (int k = 0; k < LC; k++) begin
        digit_valid = hold ? 1'b1 : 1'($urandom);
        exp = {1'b0, 1'b1, 1'b1, 1'b0, exp_mode, 1'b0, 1'b1, 4'(MF)};
        vectors++;
        if (obs_vec() !== exp) begin
          miscompares++;
          $display("FAIL %s_lockout k%0d: got %b want %b", tag, k, obs_vec(), exp);
        end
        step();
      end
      fc = 0;
    end else begin
      fc = fc + 1;
    end
    exp = {1'b1, 1'b0, 1'b1, 1'b0, exp_mode, 1'b0, 1'b0, 4'(fc)};
    vectors++;
    if (obs_vec() !== exp) begin
      miscompares++;
      $display("FAIL %s_idle_after: got %b want %b", tag, obs_vec(), exp);
    end
  endtask

  task automatic test_reset();
    logic [10:0] exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    #1 reset = 1'b1;
    #2;
    vectors++;
    if (obs_vec() !== exp) begin
      miscompares++;
      $display("FAIL reset_async: got %b want %b", obs_vec(), exp);
    end
    step();
    step();
    reset = 1'b0;
    step();
    vectors++;
    if (obs_vec() !== exp) begin
      miscompares++;
      $display("FAIL reset_release: got %b want %b", obs_vec(), exp);
    end
    fc = 0;
    exp_mode = 1'b0;
  endtask

  task automatic test_unlock();
    run_attempt(4'b1111, 1'($urandom), 1'b0, 1'b0, "unlock");
    digit_valid = 1'b0;
  endtask

  task automatic test_lockout();
    for (int i = 0; i < MF; i++) run_attempt(4'b1110, 1'($urandom), 1'b0, 1'b0, "lockout");
    digit_valid = 1'b0;
  endtask

  task automatic test_recover();
    logic [3:0] c;
    for (int i = 0; i < 2; i++) begin
      c = 4'($urandom_range(0, 14));
      run_attempt(c, 1'($urandom), 1'b0, 1'b0, "recover_fail");
    end
    run_attempt(4'b1111, 1'($urandom), 1'b0, 1'b0, "recover_ok");
    digit_valid = 1'b0;
  endtask

  task automatic test_hold_valid();
    run_attempt(4'b1111, 1'b0, 1'b0, 1'b1, "hold");
    for (int i = 0; i < 4; i++) run_attempt(4'($urandom), 1'($urandom), 1'b0, 1'b1, "hold");
    digit_valid = 1'b0;
  endtask

  task automatic test_mode_toggle();
    run_attempt(4'b1111, 1'b1, 1'b1, 1'b0, "mode_hi");
    run_attempt(4'b0101, 1'b0, 1'b1, 1'b0, "mode_lo");
    digit_valid = 1'b0;
  endtask

  task automatic test_reset_mid_feed();
    logic [10:0] exp;
    if (fc == MF - 1) run_attempt(4'b1111, 1'b1, 1'b0, 1'b0, "pre_clear");
    run_attempt(4'b0011, 1'b1, 1'b0, 1'b0, "pre_fail");
    mode_sel = 1'b1;
    for (int i = 0; i < L; i++) begin
      digit_valid = 1'b1;
      digit_bit   = 1'b1;
      step();
    end
    digit_valid = 1'b0;
    step();
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'(fc)};
    vectors++;
    if (obs_vec() !== exp) begin
      miscompares++;
      $display("FAIL midfeed_pre: got %b want %b", obs_vec(), exp);
    end
    #2 reset = 1'b1;
    #1;
    exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vectors++;
    if (obs_vec() !== exp) begin
      miscompares++;
      $display("FAIL midfeed_reset: got %b want %b", obs_vec(), exp);
    end
    #2 reset = 1'b0;
    fc = 0;
    exp_mode = 1'b0;
    run_attempt(4'b1111, 1'b0, 1'b0, 1'b0, "after_reset");
    run_attempt(4'b1011, 1'b1, 1'b0, 1'b0, "after_reset_fail");
    digit_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] c;
    for (int i = 0; i < 12; i++) begin
      c = ($urandom_range(0, 9) < 3) ? 4'b1111 : 4'($urandom);
      run_attempt(c, 1'($urandom), 1'($urandom), 1'($urandom), "random");
    end
    digit_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_recover();
    test_hold_valid();
    test_mode_toggle();
    test_reset_mid_feed();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 Parameter CODE_LEN, default 4, meaning digits per entry attempt (range 1..16).
REQ-002 Parameter MAX_FAILS, default 3, meaning consecutive failed attempts that trigger lockout (range 1..15).
REQ-003 Parameter LOCKOUT_CYCLES, default 16, meaning lockout duration in clock cycles (range 1..65535).
REQ-004 Parameter UNLOCK_CYCLES, default 8, meaning unlocked pulse duration in clock cycles (range 1..65535).
REQ-005 clock  input  1  single system clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 digit_valid  input  1  user digit present.
REQ-008 digit_bit  input  1  digit value, qualified by digit_valid.
REQ-009 digit_ready  output  1  sequencer accepts a digit this cycle.
REQ-010 mode_sel  input  1  accepter mode, forwarded to acc_switch and latched at the first digit of each attempt.
REQ-011 acc_next_digit  output  1  digit driven into the code accepter.
REQ-012 acc_switch  output  1  mode driven into the code accepter.
REQ-013 acc_reset  output  1  holds the code accepter in its reset state.
REQ-014 acc_accept  input  1  registered accept flag from the code accepter.
REQ-015 unlocked  output  1  attempt passed; high for UNLOCK_CYCLES.
REQ-016 locked_out  output  1  lockout active.
REQ-017 fail_count  output  4  consecutive failed attempts.
REQ-018 busy  output  1  high in every state except IDLE and COLLECT.

Function
REQ-019 States: IDLE, COLLECT, FEED, CHECK, UNLOCK, LOCKOUT.
REQ-020 digit_ready is high only in IDLE and COLLECT; a digit transfers when digit_valid && digit_ready.
REQ-021 In IDLE, a transfer stores the digit at buffer index 0, latches mode_sel, and moves to COLLECT, or to FEED directly when CODE_LEN==1.
REQ-022 In COLLECT, each transfer stores the digit at the next index; the transfer of digit CODE_LEN-1 moves to FEED.
REQ-023 acc_reset is 1 in IDLE, COLLECT, UNLOCK and LOCKOUT, and 0 in FEED and CHECK.
REQ-024 FEED lasts exactly CODE_LEN cycles; in cycle k, acc_next_digit equals buffered digit k, in entry order.
REQ-025 acc_next_digit is 0 outside FEED; acc_switch equals the latched mode at all times.
REQ-026 CHECK lasts one cycle and samples acc_accept.
REQ-027 If acc_accept==1: clear fail_count and go to UNLOCK.
REQ-028 If acc_accept==0 and fail_count+1==MAX_FAILS: set fail_count to MAX_FAILS and go to LOCKOUT.
REQ-029 If acc_accept==0 otherwise: increment fail_count and go to IDLE.
REQ-030 Latency from final digit transfer to unlocked=1 is CODE_LEN+2 cycles.
REQ-031 unlocked is registered, high for exactly UNLOCK_CYCLES cycles, then the block returns to IDLE.
REQ-032 locked_out is registered, high for exactly LOCKOUT_CYCLES cycles; the block then clears fail_count and returns to IDLE.
REQ-033 Digits presented while busy are not accepted, because digit_ready is 0; no buffering occurs outside IDLE/COLLECT.
REQ-034 mode_sel changes mid-attempt have no effect until the next attempt.
REQ-035 Timer and digit-index counters are wide enough for the maximum parameter values; there is no wrap inside one state.

Reset
REQ-036 Asserting reset in any state, including mid-FEED or mid-LOCKOUT, forces IDLE immediately.
REQ-037 Reset values: digit_ready=1, acc_reset=1, acc_next_digit=0, acc_switch=0, unlocked=0, locked_out=0, fail_count=0, busy=0.
REQ-038 Reset clears the buffer, latched mode, digit index and timers.

Structure
REQ-039 A shared package holds the state enum, counter width constants and parameter default constants.
REQ-040 One sub-module, lock_timer, is a loadable down-counter with done flag, shared by UNLOCK and LOCKOUT.
REQ-041 The code accepter is instantiated by the parent, not inside lock_sequencer.

Verification
REQ-042 Bench pairs the block with an accepter stub: acc_accept registers 1 one edge after FEED ends when the fed bits are 1,1,1,1, else 0.
REQ-043 Scenario: enter 1,1,1,1 -> acc_next_digit 1,1,1,1 in four FEED cycles; unlocked=1 for 8 cycles starting 6 cycles after the final transfer; fail_count=0.
REQ-044 Scenario: enter 0,1,1,1 three times -> fail_count goes 1, 2, then locked_out=1 for 16 cycles; digit_ready=0 throughout; afterwards fail_count=0 and state is IDLE.
REQ-045 Scenario: two failures then a correct entry -> unlocked pulse and fail_count cleared to 0.
REQ-046 Scenario: digit_valid held high continuously -> exactly CODE_LEN digits taken per attempt, none during FEED/CHECK/UNLOCK.
REQ-047 Scenario: reset asserted in FEED cycle 2 -> outputs at reset values without waiting for a clock; the next attempt is evaluated from digit 0.
REQ-048 Scenario: mode_sel=1 at first digit, toggled mid-entry -> acc_switch stays 1 for the whole attempt.
